// File: rtl/uart_wb_master.sv
// UART 8N1 host link to a Wishbone classic master: 'W'/'R' commands with big-endian
// address/data, one bus cycle per command, replies 'K', read data, 'E' or '?'.
module uart_wb_master #(
    parameter int CLK_FREQ   = 24000000,
    parameter int BAUD       = 115200,
    parameter int WB_TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        busy
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(WB_TIMEOUT + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_BUS, P_REPLY} p_state_t;

    logic       rx_s1, rx_s2, rx_prev;
    rx_state_t  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_sh, rx_byte;
    logic       rx_valid, rx_ferr;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_prev && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_cnt   <= '0;
                end
                RX_START: if (rx_cnt == 16'(HALF - 1)) begin
                    // a line already back high mid-start-bit was a glitch
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                end else rx_cnt <= rx_cnt + 16'd1;
                RX_DATA: if (rx_cnt == 16'(CPB - 1)) begin
                    rx_cnt <= '0;
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state <= RX_STOP;
                end else rx_cnt <= rx_cnt + 16'd1;
                RX_STOP: if (rx_cnt == 16'(CPB - 1)) begin
                    rx_cnt   <= '0;
                    rx_state <= RX_IDLE;
                    if (rx_s2) begin
                        rx_valid <= 1'b1;
                        rx_byte  <= rx_sh;
                    end else rx_ferr <= 1'b1;
                end else rx_cnt <= rx_cnt + 16'd1;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    p_state_t    state;
    logic        is_write;
    logic [1:0]  byte_cnt;
    logic [TW-1:0] tcnt;
    logic [31:0] reply_buf;
    logic [2:0]  reply_n;
    logic        tx_on;
    logic [8:0]  tx_sh;
    logic [3:0]  tx_bit;
    logic [15:0] tx_cnt;
    logic        tx_bit_end, tx_load;

    assign tx_bit_end = (tx_cnt == 16'(CPB - 1));
    // load the first reply byte, or the next one straight after a finished stop bit
    assign tx_load = (state == P_REPLY) &&
                     (!tx_on || (tx_bit_end && tx_bit == 4'd9 && reply_n != 3'd0));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= P_CMD;
            is_write  <= 1'b0;
            byte_cnt  <= '0;
            tcnt      <= '0;
            reply_buf <= '0;
            reply_n   <= '0;
            tx_on     <= 1'b0;
            tx_sh     <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
            uart_tx   <= 1'b1;
            busy      <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
        end else begin
            case (state)
                P_CMD: if (rx_valid) begin
                    busy     <= 1'b1;
                    byte_cnt <= '0;
                    if (rx_byte == 8'h57 || rx_byte == 8'h52) begin
                        is_write <= (rx_byte == 8'h57);
                        state    <= P_ADDR;
                    end else begin
                        reply_buf <= {8'h3F, 24'h0};
                        reply_n   <= 3'd1;
                        tx_on     <= 1'b0;
                        state     <= P_REPLY;
                    end
                end
                P_ADDR, P_DATA: if (rx_ferr) begin
                    state <= P_CMD;
                    busy  <= 1'b0;
                end else if (rx_valid) begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (state == P_ADDR) wbm_adr_o <= {wbm_adr_o[23:0], rx_byte};
                    else                 wbm_dat_o <= {wbm_dat_o[23:0], rx_byte};
                    if (byte_cnt == 2'd3) begin
                        if (state == P_ADDR && is_write) state <= P_DATA;
                        else begin
                            state     <= P_BUS;
                            tcnt      <= '0;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_sel_o <= 4'hF;
                            wbm_we_o  <= is_write;
                        end
                    end
                end
                P_BUS: if (wbm_err_i || wbm_ack_i || tcnt == TW'(WB_TIMEOUT - 1)) begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_sel_o <= 4'h0;
                    wbm_we_o  <= 1'b0;
                    tx_on     <= 1'b0;
                    state     <= P_REPLY;
                    reply_n   <= 3'd1;
                    if (wbm_err_i || !wbm_ack_i) reply_buf <= {8'h45, 24'h0};
                    else if (wbm_we_o)           reply_buf <= {8'h4B, 24'h0};
                    else begin
                        reply_buf <= wbm_dat_i;
                        reply_n   <= 3'd4;
                    end
                end else tcnt <= tcnt + TW'(1);
                P_REPLY: if (tx_load) begin
                    tx_on     <= 1'b1;
                    uart_tx   <= 1'b0;
                    tx_sh     <= {1'b1, reply_buf[31:24]};
                    reply_buf <= {reply_buf[23:0], 8'h00};
                    reply_n   <= reply_n - 3'd1;
                    tx_bit    <= '0;
                    tx_cnt    <= '0;
                end else if (tx_bit_end) begin
                    tx_cnt <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_on <= 1'b0;
                        busy  <= 1'b0;
                        state <= P_CMD;
                    end else begin
                        uart_tx <= tx_sh[0];
                        tx_sh   <= {1'b1, tx_sh[8:1]};
                        tx_bit  <= tx_bit + 4'd1;
                    end
                end else tx_cnt <= tx_cnt + 16'd1;
                default: state <= P_CMD;
            endcase
        end
    end

endmodule

// File: doc/uart_wb_master.md
# uart_wb_master

Host-side debug bridge: a UART 8N1 receiver/transmitter pair driving a Wishbone classic master port. It gives a PC on the board's USB-UART direct read/write access to the SoC's Wishbone address space, independent of CPU firmware. It is the initiator end of the link that the SoC's console UART otherwise serves. It is instantiated in board tops next to `picorv32_wb_soc`, on the same `wb_clk` domain.

## Interface

- `CLK_FREQ`, 24000000: clock frequency in Hz.
- `BAUD`, 115200: line rate.
- `WB_TIMEOUT`, 1024: clocks allowed for ack/err before a bus cycle is abandoned.
- (derived) `CLKS_PER_BIT` = CLK_FREQ/BAUD, integer truncation; the value must be ≥ 4.

- `clock`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `uart_rx`  in  1  serial input from host; asynchronous, idles high.
- `uart_tx`  out  1  serial output to host; idles high.
- `wbm_adr_o`  out  32  byte address.
- `wbm_dat_o`  out  32  write data.
- `wbm_sel_o`  out  4  byte lanes; always 4'hF during a cycle.
- `wbm_we_o`  out  1  write enable.
- `wbm_cyc_o`, `wbm_stb_o`  out  1  cycle/strobe; asserted and deasserted together.
- `wbm_dat_i`  in  32  read data.
- `wbm_ack_i`, `wbm_err_i`  in  1  termination.
- `busy`  out  1  high from the first command byte until the last reply stop bit.

## Operation

- **RX:**
  - `uart_rx` passes through a 2-FF synchronizer.
  - Start is detected on a high→low transition.
  - At CLKS_PER_BIT/2 the line is re-sampled. If it is high, this is a glitch and the receiver returns to idle.
  - 8 data bits, LSB first, are sampled every CLKS_PER_BIT after that.
  - Stop bit sampled low → framing error: the byte is dropped and the parser returns to CMD.
- **Parser states:** CMD, ADDR, DATA, BUS, REPLY.
  - CMD, 0x57 'W': go to ADDR, expecting 4 address bytes then 4 data bytes.
  - CMD, 0x52 'R': go to ADDR, expecting 4 address bytes.
  - CMD, any other byte: reply 0x3F '?' and return to CMD.
  - Address and data are big-endian: the first byte received goes to bits [31:24].
  - After the last expected byte the parser enters BUS.
- **BUS:**
  - Drives cyc/stb/we/adr/dat and holds them until `wbm_ack_i`, `wbm_err_i`, or WB_TIMEOUT clocks have elapsed.
  - cyc/stb drop on the clock after termination.
  - If ack and err are asserted in the same cycle, err wins.
- **REPLY:**
  - Write ack → 0x4B 'K'.
  - Read ack → 4 bytes of captured `wbm_dat_i`, MSB byte first.
  - err or timeout → 0x45 'E'. A failed read sends only 'E'.
- **TX:** start bit (0), 8 data bits LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT clocks.
- **Bytes during BUS/REPLY:** bytes received while in BUS or REPLY are discarded. The host must wait for the reply.
- **Reset mid-operation:** an active cycle is aborted with cyc/stb low the next clock. A TX byte in progress is truncated and `uart_tx` goes high immediately. The parser returns to CMD.

## Timing

- **Reset values:**
  - `uart_tx`=1.
  - `wbm_cyc_o`=`wbm_stb_o`=`wbm_we_o`=0.
  - `wbm_adr_o`=`wbm_dat_o`=0.
  - `wbm_sel_o`=0.
  - `busy`=0.
- **Command to bus:** `wbm_cyc_o` rises 1 clock after the last byte's stop-bit sample.
- **Bus latency:** minimum 1-cycle bus cycle when ack is asserted in the first stb cycle.
- **Timeout:** cycle abandoned when the counter reaches WB_TIMEOUT with no termination. cyc is high for exactly WB_TIMEOUT clocks.
- **Reply start:** the reply start bit begins 1 clock after cyc falls.
- **Reply spacing:** multi-byte replies are back-to-back, with no idle bits between stop and next start.
- **busy:** falls on the clock after the final stop bit completes.
- **Outputs:** all outputs are registered.

## Test plan

Sim parameters: CLK_FREQ=1000000, BAUD=100000 (10 clk/bit), WB_TIMEOUT=16, with a Wishbone memory model attached.

- **Write:** send 57 00 00 10 00 DE AD BE EF → one cycle with adr=0x00001000, dat=0xDEADBEEF, we=1, sel=F; reply 0x4B; `busy` low afterwards.
- **Read:** send 52 00 00 10 00 → one cycle with we=0; reply bytes DE AD BE EF in that order, each frame exactly 100 clocks, back-to-back.
- **Timeout:** read an unmapped address whose slave never acks → cyc high exactly 16 clocks; reply 0x45 only.
- **Slave error:** slave asserts err together with ack → reply 0x45; the cycle is 1 clock long.
- **Bad input:** send 0x41 → reply 0x3F. Then send a byte with its stop bit forced low in the middle of an ADDR phase → no bus cycle occurs; a following valid read succeeds.
- **Reset mid-operation:** assert reset during BUS state → cyc/stb=0 and `uart_tx`=1 on the next clock. A subsequent write completes normally.
